// File: rtl/arf_pkg.sv
// Shared definitions for the ARF stream controller: FSM encoding, lane count,
// and DP_LAT limits with a helper that turns DP_LAT into a wait-counter preload.
package arf_pkg;

  localparam int unsigned ARF_NX     = 8;
  localparam int unsigned DP_LAT_MIN = 1;
  localparam int unsigned DP_LAT_MAX = 255;
  localparam int unsigned LAT_CNT_W  = 8;
  localparam int unsigned SCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } arf_state_e;

  // Clamp DP_LAT into its legal range and return the preload (DP_LAT-1).
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int unsigned dp_lat);
    int unsigned l;
    l = dp_lat;
    if (l < DP_LAT_MIN) l = DP_LAT_MIN;
    if (l > DP_LAT_MAX) l = DP_LAT_MAX;
    return LAT_CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/arf_lat_cnt.sv
// Loadable down-counter with a zero flag; times how long operands are held
// before the datapath results are sampled.
module arf_lat_cnt
  import arf_pkg::*;
#(
  parameter int unsigned W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/arf_stream_ctrl.sv
// One-in-flight stream controller around an external ARF datapath.
// Optional feature macro: ARF_STATE_CLEAR_EN adds a state_clear input.
module arf_stream_ctrl
  import arf_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DP_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ARF_STATE_CLEAR_EN
  input  logic                    state_clear,
`endif
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ARF_NX*WIDTH-1:0] s_data,
  output logic [ARF_NX*WIDTH-1:0] dp_x,
  output logic [WIDTH-1:0]        dp_s13,
  output logic [WIDTH-1:0]        dp_s14,
  input  logic [WIDTH-1:0]        dp_y27,
  input  logic [WIDTH-1:0]        dp_y28,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*WIDTH-1:0]      m_data,
  output logic [SCNT_W-1:0]       sample_cnt
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(DP_LAT);

  arf_state_e        state_q;
  arf_state_e        state_d;
  logic              ld_x;
  logic              cap;
  logic              acc;
  logic              cnt_dec;
  logic              cnt_zero_c;
  logic [SCNT_W-1:0] sample_cnt_d;

  arf_lat_cnt #(
    .W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_x),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  assign s_ready = (state_q == IDLE) && !rst;
  assign m_valid = (state_q == OUT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    ld_x    = 1'b0;
    cap     = 1'b0;
    acc     = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          ld_x    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          cap     = 1'b1;
          state_d = OUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      OUT: begin
        if (m_ready) begin
          acc     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample_cnt_d = sample_cnt + SCNT_W'(acc);

  // Operand, result and feedback registers; results are taken bit-exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_x       <= '0;
      dp_s13     <= '0;
      dp_s14     <= '0;
      m_data     <= '0;
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt_d;
      if (ld_x) begin
        dp_x <= s_data;
      end
      if (cap) begin
        m_data <= {dp_y28, dp_y27};
      end
`ifdef ARF_STATE_CLEAR_EN
      // A clear coinciding with capture wins for the feedback state only.
      if (state_clear) begin
        dp_s13 <= '0;
        dp_s14 <= '0;
      end else if (cap) begin
        dp_s13 <= dp_y27;
        dp_s14 <= dp_y28;
      end
`else
      if (cap) begin
        dp_s13 <= dp_y27;
        dp_s14 <= dp_y28;
      end
`endif
    end
  end

endmodule

// File: tb/tb_arf_stream_ctrl.sv
// Scoreboard bench for arf_stream_ctrl with a combinational ARF datapath model
// (y27 = sum(x) + s13, y28 = x1 - s14).
module tb_arf_stream_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [8*W-1:0] s_data;
  logic [8*W-1:0] dp_x;
  logic [W-1:0]   dp_s13;
  logic [W-1:0]   dp_s14;
  logic [W-1:0]   dp_y27;
  logic [W-1:0]   dp_y28;
  logic           m_valid;
  logic           m_ready;
  logic [2*W-1:0] m_data;
  logic [15:0]    sample_cnt;
`ifdef ARF_STATE_CLEAR_EN
  logic           state_clear;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] sb[$];
  logic [W-1:0]   exp_s13 = '0;
  logic [W-1:0]   exp_s14 = '0;
  logic [15:0]    exp_cnt = '0;

  arf_stream_ctrl #(
    .WIDTH  (W),
    .DP_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ARF_STATE_CLEAR_EN
    .state_clear (state_clear),
`endif
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .dp_x        (dp_x),
    .dp_s13      (dp_s13),
    .dp_s14      (dp_s14),
    .dp_y27      (dp_y27),
    .dp_y28      (dp_y28),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External datapath stand-in.
  always_comb begin
    logic [W-1:0] s;
    s = dp_s13;
    for (int i = 0; i < 8; i++) s = s + dp_x[i*W +: W];
    dp_y27 = s;
    dp_y28 = dp_x[W-1:0] - dp_s14;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_set(input logic [8*W-1:0] d, output int hs);
    int           budget;
    logic [W-1:0] y27;
    logic [W-1:0] y28;
    budget  = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL s_ready_wait got=%b exp=1", s_ready);
    end
    hs  = cyc;
    y27 = exp_s13;
    for (int i = 0; i < 8; i++) y27 = y27 + d[i*W +: W];
    y28 = d[W-1:0] - exp_s14;
    sb.push_back({y28, y27});
    exp_s13 = y27;
    exp_s14 = y28;
    tick();
    s_valid = 1'b0;
    total++;
    if (dp_x !== d) begin
      bad++;
      $display("FAIL dp_x_load got=%h exp=%h", dp_x, d);
    end
  endtask

  task automatic recv(input int hs, input int stall, output logic [2*W-1:0] got);
    int             budget;
    logic [2*W-1:0] held;
    logic [2*W-1:0] exp;
    budget = 0;
    got    = 'x;
    while (m_valid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    total++;
    if (m_valid !== 1'b1) begin
      bad++;
      $display("FAIL m_valid_timeout got=%b exp=1", m_valid);
      return;
    end
    total++;
    if ((cyc - hs) != int'(LAT + 1)) begin
      bad++;
      $display("FAIL latency got=%0d exp=%0d", cyc - hs, LAT + 1);
    end
    held = m_data;
    for (int k = 0; k < stall; k++) begin
      s_valid = k[0];
      s_data  = {$urandom, $urandom, $urandom, $urandom};
      total++;
      if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold k=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                 k, m_valid, m_data, s_ready, held);
      end
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    got     = m_data;
    exp     = 'x;
    if (sb.size() > 0) exp = sb.pop_front();
    total++;
    if (m_data !== exp) begin
      bad++;
      $display("FAIL m_data got=%h exp=%h", m_data, exp);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++;
    if (sample_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL sample_cnt got=%h exp=%h", sample_cnt, exp_cnt);
    end
    total++;
    if (dp_s13 !== exp_s13 || dp_s14 !== exp_s14) begin
      bad++;
      $display("FAIL feedback got=%h/%h exp=%h/%h", dp_s13, dp_s14, exp_s13, exp_s14);
    end
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_xfer got v=%b rdy=%b exp v=0 rdy=1", m_valid, s_ready);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    tick();
    tick();
    total++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || sample_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b v=%b cnt=%h exp 0/0/0000", s_ready, m_valid, sample_cnt);
    end
    total++;
    if (dp_x !== '0 || dp_s13 !== '0 || dp_s14 !== '0 || m_data !== '0) begin
      bad++;
      $display("FAIL reset_data got x=%h s13=%h s14=%h m=%h exp all 0", dp_x, dp_s13, dp_s14, m_data);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got=%b exp=1", s_ready);
    end
  endtask

  task automatic test_basic;
    int             hs;
    logic [2*W-1:0] got;
    send_set({8{16'h0001}}, hs);
    recv(hs, 0, got);
    total++;
    if (got !== 32'h0001_0008 || dp_s13 !== 16'h0008 || dp_s14 !== 16'h0001) begin
      bad++;
      $display("FAIL first_set got=%h s13=%h s14=%h exp=00010008 0008 0001", got, dp_s13, dp_s14);
    end
    send_set({8{16'h0001}}, hs);
    recv(hs, 0, got);
    total++;
    if (got !== 32'h0000_0010 || sample_cnt !== 16'h0002) begin
      bad++;
      $display("FAIL second_set got=%h cnt=%h exp=00000010 0002", got, sample_cnt);
    end
  endtask

  task automatic test_stall;
    int             hs;
    logic [2*W-1:0] got;
    logic [8*W-1:0] d;
    d       = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b0;
    send_set(d, hs);
    recv(hs, 5, got);
    total++;
    if (dp_x !== d) begin
      bad++;
      $display("FAIL stall_ignore got=%h exp=%h", dp_x, d);
    end
  endtask

  task automatic test_back_to_back;
    int             hs;
    logic [2*W-1:0] got;
    logic [8*W-1:0] pats[6];
    pats[0] = {8{16'hFFFF}};
    pats[1] = '0;
    pats[2] = {16'h8000, 16'h0001, 16'h7FFF, 16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0, 16'h5555};
    for (int i = 3; i < 6; i++) pats[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      send_set(pats[i], hs);
      recv(hs, 0, got);
    end
  endtask

  task automatic test_reset_wait;
    int hs;
    logic [8*W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    send_set(d, hs);
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || sample_cnt !== 16'h0000 ||
        dp_s13 !== '0 || dp_s14 !== '0 || dp_x !== '0) begin
      bad++;
      $display("FAIL reset_wait got v=%b rdy=%b cnt=%h s13=%h s14=%h exp 0/0/0000/0/0",
               m_valid, s_ready, sample_cnt, dp_s13, dp_s14);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_wait_release got=%b exp=1", s_ready);
    end
    sb.delete();
    exp_s13 = '0;
    exp_s14 = '0;
    exp_cnt = '0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (m_valid !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
        bad++;
        $display("FAIL discarded_emitted got=%0d exp=0", seen);
      end
    end
  endtask

  task automatic test_wrap;
    int             hs;
    logic [2*W-1:0] got;
    // Preload the counter just below wrap while idle.
    force dut.sample_cnt_d = 16'hFFFE;
    tick();
    release dut.sample_cnt_d;
    exp_cnt = 16'hFFFE;
    total++;
    if (sample_cnt !== 16'hFFFE) begin
      bad++;
      $display("FAIL cnt_preload got=%h exp=fffe", sample_cnt);
    end
    send_set({$urandom, $urandom, $urandom, $urandom}, hs);
    recv(hs, 0, got);
    send_set({$urandom, $urandom, $urandom, $urandom}, hs);
    recv(hs, 0, got);
    total++;
    if (sample_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL cnt_wrap got=%h exp=0000", sample_cnt);
    end
  endtask

`ifdef ARF_STATE_CLEAR_EN
  task automatic test_clear;
    int             hs;
    logic [2*W-1:0] got;
    send_set({8{16'h0003}}, hs);
    tick();
    state_clear = 1'b1;
    tick();
    state_clear = 1'b0;
    exp_s13 = '0;
    exp_s14 = '0;
    total++;
    if (dp_s13 !== '0 || dp_s14 !== '0 || m_valid !== 1'b1) begin
      bad++;
      $display("FAIL state_clear got s13=%h s14=%h v=%b exp 0/0/1", dp_s13, dp_s14, m_valid);
    end
    recv(hs, 0, got);
  endtask
`endif

  initial begin
`ifdef ARF_STATE_CLEAR_EN
    state_clear = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_wait();
    test_wrap();
`ifdef ARF_STATE_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arf_stream_ctrl.md
ARF_STREAM_CTRL -- requirements
Module: arf_stream_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, data width of every sample, operand and result.
REQ-002 Parameter DP_LAT, default 2, cycles the registered operands are held before the ARF datapath results are sampled; legal range 1..255.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_valid  in  1  upstream sample-set valid.
REQ-006 s_ready  out  1  block can accept a sample set.
REQ-007 s_data  in  8*WIDTH  eight new input operands, lane k (bits k*WIDTH+:WIDTH) drives datapath multiplier k+1 input 0.
REQ-008 dp_x  out  8*WIDTH  registered operands to datapath inputs in_1_0..in_8_0, same lane order.
REQ-009 dp_s13, dp_s14  out  WIDTH each  registered feedback state to datapath in_13_1 and in_14_1.
REQ-010 dp_y27, dp_y28  in  WIDTH each  datapath results out_27, out_28.
REQ-011 m_valid  out  1  result pair valid.
REQ-012 m_ready  in  1  downstream accepts result pair.
REQ-013 m_data  out  2*WIDTH  {y28, y27}, y27 in low half.
REQ-014 sample_cnt  out  16  completed result transfers, wraps 0xFFFF->0x0000.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, OUT; encoding in shared package.
REQ-016 s_ready SHALL be 1 only in IDLE and not in reset; m_valid SHALL be 1 only in OUT.
REQ-017 IDLE: on s_valid&&s_ready, dp_x SHALL load s_data, wait counter loads DP_LAT-1, go WAIT.
REQ-018 WAIT: counter decrements each cycle; in the cycle counter==0, m_data loads {dp_y28,dp_y27}, dp_s13<=dp_y27, dp_s14<=dp_y28, go OUT.
REQ-019 Latency: handshake at cycle t SHALL give m_valid high first at cycle t+DP_LAT+1.
REQ-020 dp_x, dp_s13, dp_s14 SHALL stay stable from load until next accepted handshake, except per REQ-024/REQ-027.
REQ-021 OUT: m_data SHALL be held stable while m_valid&&!m_ready; on m_valid&&m_ready go IDLE and sample_cnt increments.
REQ-022 No overlap: at most one sample set in flight; s_valid in WAIT/OUT SHALL be ignored (s_ready=0).
REQ-023 Arithmetic: no arithmetic on data; results captured bit-exact, no truncation or extension.

Reset
REQ-024 On rst high at any clock edge, next cycle: state IDLE, dp_x=0, dp_s13=0, dp_s14=0, m_data=0, m_valid=0, s_ready=0 while rst high, sample_cnt=0, wait counter=0.
REQ-025 Reset mid-WAIT or mid-OUT SHALL discard the in-flight set; no result emitted, counter not incremented.
REQ-026 First cycle after rst deasserts SHALL show s_ready=1.

Configuration
REQ-027 With ARF_STATE_CLEAR_EN defined: extra input state_clear (1 bit); when high at an edge, dp_s13 and dp_s14 SHALL become 0 next cycle in any state; coinciding with the REQ-018 capture, clear wins for state, m_data still captures results; FSM unaffected.
REQ-028 Without ARF_STATE_CLEAR_EN: no state_clear port; feedback state changes only via REQ-018 and reset.

Structure
REQ-029 Package arf_pkg SHALL hold the FSM state typedef, lane count constant ARF_NX=8, and DP_LAT range limits.
REQ-030 One sub-module arf_lat_cnt (loadable down-counter with zero flag) SHALL implement the wait counter; all else in arf_stream_ctrl.
REQ-031 The ARF datapath itself SHALL NOT be instantiated inside this block; connection is at the parent.

Verification (WIDTH=16, DP_LAT=2, bench models datapath as y27=sum(x)+s13, y28=x1-s14, combinational)
REQ-032 Reset then s_data lanes all 0x0001, m_ready=1 -> m_valid at t+3, m_data={0x0001,0x0008}, sample_cnt=1, dp_s13=0x0008, dp_s14=0x0001.
REQ-033 Second identical set -> m_data={0x0000,0x0010} using fed-back state; sample_cnt=2.
REQ-034 m_ready=0 for 5 cycles in OUT -> m_valid, m_data stable 5 cycles, s_ready=0, s_valid pulses ignored.
REQ-035 rst asserted in second WAIT cycle -> no m_valid, sample_cnt=0, dp_s13=dp_s14=0, s_ready=1 after release.
REQ-036 sample_cnt preloaded via 65535 transfers, one more -> 0x0000.
REQ-037 ARF_STATE_CLEAR_EN defined, state_clear in capture cycle -> m_data per model, dp_s13=dp_s14=0 next cycle.
